// File: rtl/uart_word_packer.sv
// Packs the UART RX byte stream MSB-first into 32-bit words and writes them to consecutive RAM
// addresses, flagging done after WORD_COUNT words. Optional idle timeout: define RX_TIMEOUT_EN.
module uart_word_packer #(
  parameter int WORD_COUNT = 2405,
  parameter int ADDR_W     = 12
`ifdef RX_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_byte_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  output logic [ADDR_W-1:0] word_cnt_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              timeout_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] partial;
  logic        accept;
  logic        last_write;
  logic        timeout_hit;

  assign accept     = en_i && rx_valid_i && (state != S_DONE);
  assign last_write = (state == S_WRITE) && (word_cnt_o == ADDR_W'(WORD_COUNT - 1));

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;
  logic          idle_tick;
  logic          timeout_err_q;

  // Only a partially filled word can time out; en_i=0 freezes the count.
  assign idle_tick   = (state == S_COLLECT) && (byte_idx != 2'd0) && en_i && !rx_valid_i;
  assign timeout_hit = idle_tick && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idle_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else if (clear_i) begin
      idle_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else if (accept || timeout_hit) begin
      idle_cnt <= '0;
      if (timeout_hit) timeout_err_q <= 1'b1;
    end else if (idle_tick) begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end

  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_err_o = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      partial    <= '0;
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      word_cnt_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else if (clear_i) begin
      // Clear outranks any byte arriving now; last written addr/data are simply held.
      state      <= S_IDLE;
      byte_idx   <= 2'd0;
      partial    <= '0;
      ram_en_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      word_cnt_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      ram_en_o <= 1'b0;
      ram_we_o <= 1'b0;

      if (state == S_WRITE) begin
        word_cnt_o <= word_cnt_o + ADDR_W'(1);
        if (last_write) begin
          state  <= S_DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else begin
          state <= S_COLLECT;
        end
      end

      if (accept && !last_write) begin
        busy_o <= 1'b1;
        if (byte_idx == 2'd3) begin
          ram_en_o   <= 1'b1;
          ram_we_o   <= 1'b1;
          ram_addr_o <= word_cnt_o;
          ram_data_o <= {partial, rx_byte_i};
          byte_idx   <= 2'd0;
          state      <= S_WRITE;
        end else begin
          partial  <= {partial[15:0], rx_byte_i};
          byte_idx <= byte_idx + 2'd1;
          state    <= S_COLLECT;
        end
      end else if (timeout_hit) begin
        byte_idx <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_packer.sv
// Scoreboard bench for uart_word_packer: stimulus pushes expected RAM writes, a monitor pops them.
module tb_uart_word_packer;

  localparam int WC = 3;
  localparam int AW = 12;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          en_i = 1'b0;
  logic          clear_i = 1'b0;
  logic          rx_valid_i = 1'b0;
  logic [7:0]    rx_byte_i = 8'h00;
  logic          ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o, word_cnt_o;
  logic [31:0]   ram_data_o;
  logic          busy_o, done_o, timeout_err_o;

  int  total = 0;
  int  bad   = 0;
  wr_t exp_q[$];

  uart_word_packer #(
    .WORD_COUNT(WC),
    .ADDR_W(AW)
`ifdef RX_TIMEOUT_EN
    ,.TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .clear_i(clear_i),
    .rx_valid_i(rx_valid_i), .rx_byte_i(rx_byte_i),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .word_cnt_o(word_cnt_o), .busy_o(busy_o),
    .done_o(done_o), .timeout_err_o(timeout_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write cycle must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk_i);
      if (rst_ni && (ram_we_o || ram_en_o)) begin
        check("ram_en_eq_we", {31'd0, ram_en_o}, {31'd0, ram_we_o});
        if (exp_q.size() == 0) begin
          check("unexpected_write", {31'd0, ram_we_o}, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", {20'd0, ram_addr_o}, {20'd0, w.addr});
          check("wr_data", ram_data_o, w.data);
        end
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  // Called #1 after a posedge; returns #1 after the edge that samples the byte.
  task automatic send_byte(input logic [7:0] b);
    rx_valid_i = 1'b1;
    rx_byte_i  = b;
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
  endtask

  initial begin
    // Reset state
    idle(2);
    check("rst_ram_en", {31'd0, ram_en_o}, 32'd0);
    check("rst_word_cnt", {20'd0, word_cnt_o}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_addr_data", {20'd0, ram_addr_o} | ram_data_o, 32'd0);
    check("rst_timeout", {31'd0, timeout_err_o}, 32'd0);
    rst_ni = 1'b1;
    en_i   = 1'b1;
    idle(1);

    // 1) single word
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    expect_wr(12'd0, 32'h11223344);
    send_byte(8'h44);
    check("t1_we_pulse", {31'd0, ram_we_o}, 32'd1);
    idle(1);
    check("t1_we_low", {31'd0, ram_we_o}, 32'd0);
    check("t1_data_hold", ram_data_o, 32'h11223344);
    check("t1_word_cnt", {20'd0, word_cnt_o}, 32'd1);
    check("t1_busy", {31'd0, busy_o}, 32'd1);

    // 2) full image of WC words, then an ignored extra byte
    do_clear();
    check("t2_clr_cnt", {20'd0, word_cnt_o}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3)
        expect_wr(AW'(i / 4), {8'(i - 3), 8'(i - 2), 8'(i - 1), 8'(i)});
      send_byte(8'(i));
    end
    idle(1);
    check("t2_done", {31'd0, done_o}, 32'd1);
    check("t2_busy", {31'd0, busy_o}, 32'd0);
    check("t2_word_cnt", {20'd0, word_cnt_o}, 32'd3);
    send_byte(8'h0C);
    idle(3);
    check("t2_cnt_after", {20'd0, word_cnt_o}, 32'd3);
    check("t2_done_sticky", {31'd0, done_o}, 32'd1);

    // 3) en_i low mid-word drops bytes but keeps the partial word
    do_clear();
    check("t3_clr_done", {31'd0, done_o}, 32'd0);
    send_byte(8'hAA); send_byte(8'hBB);
    en_i = 1'b0;
    send_byte(8'h01); send_byte(8'h02);
    idle(2);
    en_i = 1'b1;
    send_byte(8'hCC);
    expect_wr(12'd0, 32'hAABBCCDD);
    send_byte(8'hDD);
    idle(1);
    check("t3_word_cnt", {20'd0, word_cnt_o}, 32'd1);

    // 4) byte arriving in the WRITE cycle starts the next word
    do_clear();
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30);
    expect_wr(12'd0, 32'h10203040);
    send_byte(8'h40);
    send_byte(8'h55);
    send_byte(8'h66); send_byte(8'h77);
    expect_wr(12'd1, 32'h55667788);
    send_byte(8'h88);
    idle(1);
    check("t4_word_cnt", {20'd0, word_cnt_o}, 32'd2);

    // 5) clear with a simultaneous byte drops it and re-arms
    do_clear();
    send_byte(8'hA1); send_byte(8'hA2);
    clear_i = 1'b1;
    send_byte(8'hA3);
    clear_i = 1'b0;
    check("t5_word_cnt", {20'd0, word_cnt_o}, 32'd0);
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3);
    expect_wr(12'd0, 32'hB1B2B3B4);
    send_byte(8'hB4);
    idle(1);
    check("t5_word_cnt2", {20'd0, word_cnt_o}, 32'd1);

    // 6) idle timeout on a partial word
    do_clear();
    send_byte(8'hC1);
    idle(20);
`ifdef RX_TIMEOUT_EN
    check("t6_timeout", {31'd0, timeout_err_o}, 32'd1);
    check("t6_word_cnt", {20'd0, word_cnt_o}, 32'd0);
    send_byte(8'hD1); send_byte(8'hD2); send_byte(8'hD3);
    expect_wr(12'd0, 32'hD1D2D3D4);
    send_byte(8'hD4);
    idle(1);
    check("t6_word_cnt2", {20'd0, word_cnt_o}, 32'd1);
    check("t6_timeout_sticky", {31'd0, timeout_err_o}, 32'd1);
`else
    check("t6_no_timeout", {31'd0, timeout_err_o}, 32'd0);
    send_byte(8'hD2); send_byte(8'hD3);
    expect_wr(12'd0, 32'hC1D2D3D4);
    send_byte(8'hD4);
    idle(1);
    check("t6_word_cnt", {20'd0, word_cnt_o}, 32'd1);
`endif

    // Reset mid-word discards the partial bytes
    send_byte(8'hE1); send_byte(8'hE2);
    rst_ni = 1'b0;
    idle(1);
    check("rst_mid_cnt", {20'd0, word_cnt_o}, 32'd0);
    check("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    rst_ni = 1'b1;
    idle(1);
    send_byte(8'hF1); send_byte(8'hF2); send_byte(8'hF3);
    expect_wr(12'd0, 32'hF1F2F3F4);
    send_byte(8'hF4);
    idle(2);
    check("rst_mid_word_cnt", {20'd0, word_cnt_o}, 32'd1);

    check("pending_writes", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
